// File: rtl/dram_arbiter.sv
// Round-robin arbiter and access sequencer between instruction fetch, the LSU and a single-port word RAM.
// Partial-strobe stores become a read-modify-write pair because the RAM has no byte enables.
module dram_arbiter #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 10,
  parameter int STRB_W   = XLEN / 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_LEN-1:0] if_addr,
  output logic                if_rsp_valid,
  output logic [XLEN-1:0]     if_rdata,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_LEN-1:0] lsu_addr,
  input  logic [XLEN-1:0]     lsu_wdata,
  input  logic [STRB_W-1:0]   lsu_wstrb,
  output logic                lsu_rsp_valid,
  output logic [XLEN-1:0]     lsu_rdata,
  output logic                busy,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_load,
  output logic                mem_store,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;
  typedef enum logic {GNT_IF = 1'b0, GNT_LSU = 1'b1} gnt_t;

  state_t              state;
  gnt_t                last_gnt;
  gnt_t                owner_q;
  logic                we_q;
  logic [XLEN-1:0]     wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                mem_store_q;
  logic                if_rsp_q;
  logic                lsu_rsp_q;
  logic [XLEN-1:0]     if_rdata_q;
  logic [XLEN-1:0]     lsu_rdata_q;

  logic                pick_lsu;
  gnt_t                winner;
  logic                acc_we;
  logic [ADDR_LEN-1:0] acc_addr;

  // On a tie the requester not granted last wins.
  always_comb begin
    pick_lsu = lsu_req && (!if_req || last_gnt == GNT_IF);
    winner   = pick_lsu ? GNT_LSU : GNT_IF;
    acc_we   = pick_lsu && lsu_we;
    acc_addr = pick_lsu ? lsu_addr : if_addr;
  end

  // NOTE: all state below is sequential, so every assignment uses <= to avoid read-order races.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      last_gnt    <= GNT_LSU;
      owner_q     <= GNT_IF;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      mem_addr    <= '0;
      mem_load    <= 1'b0;
      mem_store_q <= 1'b0;
      if_rsp_q    <= 1'b0;
      lsu_rsp_q   <= 1'b0;
      if_rdata_q  <= '0;
      lsu_rdata_q <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || lsu_req) begin
            owner_q  <= winner;
            last_gnt <= winner;
            we_q     <= acc_we;
            wdata_q  <= lsu_wdata;
            wstrb_q  <= lsu_wstrb;
            mem_addr <= acc_addr;
            busy     <= 1'b1;
            if (!acc_we) begin
              state    <= RD;
              mem_load <= 1'b1;
            end else if (lsu_wstrb == '1) begin
              state       <= WR;
              mem_store_q <= 1'b1;
            end else if (lsu_wstrb == '0) begin
              state     <= RESP;
              lsu_rsp_q <= 1'b1;
            end else begin
              state    <= RMW_RD;
              mem_load <= 1'b1;
            end
          end
        end
        RD: begin
          state     <= RESP;
          mem_load  <= 1'b0;
          if_rsp_q  <= (owner_q == GNT_IF);
          lsu_rsp_q <= (owner_q == GNT_LSU);
        end
        RMW_RD: begin
          state       <= RMW_WR;
          mem_load    <= 1'b0;
          mem_store_q <= 1'b1;
        end
        WR, RMW_WR: begin
          state       <= RESP;
          mem_store_q <= 1'b0;
          lsu_rsp_q   <= 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          if_rsp_q  <= 1'b0;
          lsu_rsp_q <= 1'b0;
          if (!we_q) begin
            if (owner_q == GNT_IF) if_rdata_q  <= mem_rdata;
            else                   lsu_rdata_q <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data arrives from the RAM during RESP; show it immediately, then hold the captured copy.
  assign if_rsp_valid  = if_rsp_q;
  assign lsu_rsp_valid = lsu_rsp_q;
  assign if_rdata      = if_rsp_q ? mem_rdata : if_rdata_q;
  assign lsu_rdata     = (lsu_rsp_q && !we_q) ? mem_rdata : lsu_rdata_q;

  // Gating with rst stops the write of a store whose final cycle is hit by reset.
  assign mem_store = mem_store_q & rst;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    mem_wdata = '0;
    if (state == WR) begin
      mem_wdata = wdata_q;
    end else if (state == RMW_WR) begin
      for (int i = 0; i < STRB_W; i++)
        mem_wdata[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : mem_rdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: fetch, RMW/full/zero stores, round-robin, reset mid-RMW, back-to-back loads.
// A behavioural registered-read RAM sits on the mem_* port.
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rdata;
  logic        lsu_req;
  logic        lsu_we;
  logic [9:0]  lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rdata;
  logic        busy;
  logic [9:0]  mem_addr;
  logic        mem_load;
  logic        mem_store;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] ram [0:1023];
  int          store_cnt   = 0;
  int          overlap_cnt = 0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dram_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .busy(busy), .mem_addr(mem_addr), .mem_load(mem_load), .mem_store(mem_store),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (pre_we)               ram[pre_addr] <= pre_data;
    if (mem_store)            ram[mem_addr] <= mem_wdata;
    if (mem_load)             mem_rdata     <= ram[mem_addr];
    if (mem_store)            store_cnt     <= store_cnt + 1;
    if (mem_load && mem_store) overlap_cnt  <= overlap_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic lsu_drive(input logic we, input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    lsu_req = 1'b1; lsu_we = we; lsu_addr = a; lsu_wdata = d; lsu_wstrb = s;
  endtask

  task automatic lsu_scramble();
    lsu_req = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wstrb = '0;
  endtask

  initial begin
    int          stores_before;
    logic        got;
    logic        exp_lsu;
    logic [31:0] prev;

    rst = 1'b0; if_req = 1'b0; if_addr = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wstrb = '0;
    tick();
    preload(10'd5, 32'hDEADBEEF);
    preload(10'd3, 32'h11223344);
    preload(10'd7, 32'h00000000);
    preload(10'd0, 32'hA0000000);
    preload(10'd1, 32'hA0000001);
    preload(10'd2, 32'hA0000002);
    preload(10'd9, 32'hCAFEF00D);

    check("rst_busy", busy, 0);
    check("rst_mem_load", mem_load, 0);
    check("rst_mem_store", mem_store, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rsp", if_rsp_valid, 0);
    check("rst_lsu_rsp", lsu_rsp_valid, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_lsu_rdata", lsu_rdata, 0);
    rst = 1'b1;
    tick();

    // Fetch read
    if_req = 1'b1; if_addr = 10'd5;
    tick();
    if_req = 1'b0; if_addr = '0;
    check("fetch_mem_load", mem_load, 1);
    check("fetch_mem_addr", mem_addr, 5);
    check("fetch_no_store", mem_store, 0);
    check("fetch_busy1", busy, 1);
    tick();
    check("fetch_rsp", if_rsp_valid, 1);
    check("fetch_rdata", if_rdata, 32'hDEADBEEF);
    check("fetch_no_lsu_rsp", lsu_rsp_valid, 0);
    check("fetch_busy2", busy, 1);
    tick();
    check("fetch_idle", busy, 0);
    check("fetch_rsp_pulse", if_rsp_valid, 0);
    check("fetch_rdata_hold", if_rdata, 32'hDEADBEEF);

    // Partial store -> RMW
    lsu_drive(1'b1, 10'd3, 32'hAABBCCDD, 4'b0101);
    tick();
    lsu_scramble();
    check("rmw_rd_load", mem_load, 1);
    check("rmw_rd_addr", mem_addr, 3);
    check("rmw_rd_no_store", mem_store, 0);
    check("rmw_rd_no_rsp", lsu_rsp_valid, 0);
    tick();
    check("rmw_wr_store", mem_store, 1);
    check("rmw_wr_no_load", mem_load, 0);
    check("rmw_wr_data", mem_wdata, 32'h11BB33DD);
    check("rmw_wr_addr", mem_addr, 3);
    tick();
    check("rmw_rsp", lsu_rsp_valid, 1);
    check("rmw_rsp_no_store", mem_store, 0);
    tick();
    check("rmw_idle", busy, 0);
    check("rmw_ram", ram[3], 32'h11BB33DD);
    lsu_drive(1'b0, 10'd3, 32'h0, 4'h0);
    tick();
    lsu_scramble();
    check("ld3_load", mem_load, 1);
    tick();
    check("ld3_rsp", lsu_rsp_valid, 1);
    check("ld3_rdata", lsu_rdata, 32'h11BB33DD);
    tick();

    // Full store
    lsu_drive(1'b1, 10'd7, 32'h12345678, 4'hF);
    tick();
    lsu_scramble();
    check("full_store", mem_store, 1);
    check("full_no_load", mem_load, 0);
    check("full_wdata", mem_wdata, 32'h12345678);
    check("full_addr", mem_addr, 7);
    tick();
    check("full_rsp", lsu_rsp_valid, 1);
    check("full_rsp_store_off", mem_store, 0);
    tick();
    check("full_ram", ram[7], 32'h12345678);
    check("full_idle", busy, 0);

    // Zero-strobe store
    stores_before = store_cnt;
    lsu_drive(1'b1, 10'd7, 32'hFFFFFFFF, 4'h0);
    tick();
    lsu_scramble();
    check("zero_rsp", lsu_rsp_valid, 1);
    check("zero_no_load", mem_load, 0);
    check("zero_no_store", mem_store, 0);
    check("zero_busy", busy, 1);
    check("zero_rdata_hold", lsu_rdata, 32'h11BB33DD);
    tick();
    check("zero_idle", busy, 0);
    check("zero_ram", ram[7], 32'h12345678);
    check("zero_store_cnt", store_cnt, stores_before);

    // Back-to-back loads
    prev = 32'h11BB33DD;
    lsu_drive(1'b0, 10'd0, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      lsu_addr = 10'(i + 1);
      check("b2b_load", mem_load, 1);
      check("b2b_addr", mem_addr, i);
      check("b2b_rdata_held", lsu_rdata, prev);
      tick();
      check("b2b_rsp", lsu_rsp_valid, 1);
      check("b2b_rdata", lsu_rdata, 32'hA0000000 + i);
      tick();
      check("b2b_rsp_pulse", lsu_rsp_valid, 0);
      check("b2b_idle", busy, 0);
      check("b2b_rdata_keep", lsu_rdata, 32'hA0000000 + i);
      if (i == 2) lsu_req = 1'b0;
      prev = 32'hA0000000 + i;
    end

    // Round-robin with both requesters held high out of reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    if_req = 1'b1; if_addr = 10'd5;
    lsu_drive(1'b0, 10'd1, 32'h0, 4'h0);
    for (int t = 0; t < 20; t++) begin
      got = 1'b0;
      for (int k = 0; k < 6; k++) begin
        tick();
        if (if_rsp_valid || lsu_rsp_valid) begin
          got = 1'b1;
          break;
        end
      end
      exp_lsu = t[0];
      check("rr_timeout", got, 1);
      check("rr_lsu_rsp", lsu_rsp_valid, exp_lsu);
      check("rr_if_rsp", if_rsp_valid, !exp_lsu);
      if (exp_lsu) check("rr_lsu_rdata", lsu_rdata, 32'hA0000001);
      else         check("rr_if_rdata", if_rdata, 32'hDEADBEEF);
    end
    if_req = 1'b0; lsu_req = 1'b0;
    tick();
    tick();
    check("rr_idle", busy, 0);

    // Reset at the edge ending RMW_RD
    stores_before = store_cnt;
    lsu_drive(1'b1, 10'd9, 32'h00000000, 4'b0011);
    tick();
    lsu_scramble();
    check("mid_rmw_rd", mem_load, 1);
    rst = 1'b0;
    tick();
    check("mid_busy", busy, 0);
    check("mid_store", mem_store, 0);
    check("mid_load", mem_load, 0);
    check("mid_lsu_rsp", lsu_rsp_valid, 0);
    check("mid_lsu_rdata", lsu_rdata, 0);
    check("mid_if_rdata", if_rdata, 0);
    tick();
    check("mid_store2", mem_store, 0);
    rst = 1'b1;
    tick();
    tick();
    check("mid_no_rsp", lsu_rsp_valid, 0);
    check("mid_store_cnt", store_cnt, stores_before);
    check("mid_ram", ram[9], 32'hCAFEF00D);
    if_req = 1'b1; if_addr = 10'd5;
    lsu_drive(1'b0, 10'd9, 32'h0, 4'h0);
    got = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (if_rsp_valid || lsu_rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if_req = 1'b0; lsu_req = 1'b0;
    check("post_rst_timeout", got, 1);
    check("post_rst_tie_fetch", if_rsp_valid, 1);
    check("post_rst_tie_no_lsu", lsu_rsp_valid, 0);
    check("post_rst_if_rdata", if_rdata, 32'hDEADBEEF);
    tick();
    tick();

    check("no_load_store_overlap", overlap_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
